iob_eth_tx_fcs: RTL and testbench



---
 rtl/iob_eth_tx_fcs_if.sv | 26 ++
 rtl/iob_eth_tx_fcs.sv | 134 +++++++++++++
 tb/tb_iob_eth_tx_fcs.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_eth_tx_fcs_if.sv
// Byte-stream handshake bundle for the Ethernet TX FCS stage.
// The upstream buffer, the serializer and the status signals share one interface.
interface iob_eth_tx_fcs_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       in_data_i;
  logic             in_valid_i;
  logic             in_last_i;
  logic             in_ready_o;
  logic [7:0]       out_data_o;
  logic             out_valid_o;
  logic             out_last_o;
  logic             out_ready_i;
  logic             busy_o;
  logic [CNT_W-1:0] len_o;

  modport master (
    output in_data_i, in_valid_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_last_o, busy_o, len_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_last_o, busy_o, len_o
  );
endinterface

// File: rtl/iob_eth_tx_fcs.sv
// Ethernet TX stage: forwards a frame, zero-pads it to a minimum length and
// appends the 4-byte CRC-32 FCS, least-significant byte first.
module iob_eth_tx_fcs #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int CNT_W         = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  iob_eth_tx_fcs_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_FRAME_LEN);

  state_t           state_reg, state_next;
  logic [31:0]      crc_reg, crc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [1:0]       idx_reg, idx_next;

  logic             in_xfer, out_xfer;
  logic [31:0]      crc_base, crc_upd;
  logic [7:0]       upd_data;
  logic [CNT_W-1:0] cnt_base, cnt_inc;
  logic [7:0]       fcs_byte [4];

  // Reflected CRC-32 (poly 0x04C11DB7 reversed), one data bit per step, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {1'b0, r[31:1]} ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
    assign fcs_byte[gi] = ~crc_reg[8*gi +: 8];
  end

  assign in_xfer  = bus.in_valid_i & bus.in_ready_o;
  assign out_xfer = bus.out_valid_o & bus.out_ready_i;

  // The first byte of a frame restarts the CRC and the count from scratch.
  assign crc_base = (state_reg == IDLE) ? 32'hFFFFFFFF : crc_reg;
  assign cnt_base = (state_reg == IDLE) ? '0 : cnt_reg;
  assign upd_data = (state_reg == PAD) ? 8'h00 : bus.in_data_i;
  assign crc_upd  = crc_byte(crc_base, upd_data);
  assign cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      crc_reg   <= 32'hFFFFFFFF;
      cnt_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE, DATA: begin
        if (in_xfer) begin
          crc_next = crc_upd;
          cnt_next = cnt_inc;
          if (bus.in_last_i) begin
            state_next = (cnt_inc < MIN_LEN) ? PAD : FCS;
          end else begin
            state_next = DATA;
          end
        end
      end
      PAD: begin
        if (out_xfer) begin
          crc_next = crc_upd;
          cnt_next = cnt_inc;
          if (cnt_inc >= MIN_LEN) begin
            state_next = FCS;
          end
        end
      end
      default: begin
        // FCS: CRC is frozen, only the byte index advances.
        if (out_xfer) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_next = IDLE;
            len_next   = cnt_reg + CNT_W'(4);
            idx_next   = 2'd0;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.out_data_o  = 8'h00;
    bus.out_last_o  = 1'b0;
    case (state_reg)
      IDLE, DATA: begin
        bus.in_ready_o  = bus.out_ready_i;
        bus.out_valid_o = bus.in_valid_i;
        bus.out_data_o  = bus.in_data_i;
      end
      PAD: begin
        bus.out_valid_o = 1'b1;
      end
      default: begin
        bus.out_valid_o = 1'b1;
        bus.out_data_o  = fcs_byte[idx_reg];
        bus.out_last_o  = (idx_reg == 2'd3);
      end
    endcase
  end

  assign bus.busy_o = (state_reg != IDLE);
  assign bus.len_o  = len_reg;

endmodule

// File: tb/tb_iob_eth_tx_fcs.sv
// Scoreboard bench for iob_eth_tx_fcs: two instances (padding to 60, padding off),
// random payloads and back-pressure, checked against a table-driven CRC-32 model.
module tb_iob_eth_tx_fcs;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    bit         last;
    bit         gen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc_cnt = 0;
  int   total = 0;
  int   bad = 0;

  iob_eth_tx_fcs_if #(.CNT_W(16)) ifa ();
  iob_eth_tx_fcs_if #(.CNT_W(16)) ifb ();

  iob_eth_tx_fcs #(.MIN_FRAME_LEN(60), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(ifa.slave)
  );
  iob_eth_tx_fcs #(.MIN_FRAME_LEN(0), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(ifb.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  exp_t expq_a[$];
  exp_t expq_b[$];
  int   lenq_a[$];
  int   lenq_b[$];
  logic [31:0] crc_tbl [256];
  bit   rand_rdy [2];
  bit   stalled [2];
  logic [7:0] held [2];
  bit   len_pend [2];
  int   last_fcs_cyc [2];

  // ---------------- reference model ----------------
  function automatic void build_tbl();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end
  endfunction

  function automatic logic [31:0] ref_fcs(input bq_t f);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (f[i]) c = (c >> 8) ^ crc_tbl[(c[7:0] ^ f[i])];
    return ~c;
  endfunction

  task automatic push_exp(input int sel, input exp_t e);
    if (sel == 0) expq_a.push_back(e);
    else          expq_b.push_back(e);
  endtask

  // Expected output of one frame: payload, zero pad up to the minimum, FCS LSB first.
  task automatic build_expected(input int sel, input bq_t p, input bit const_fcs);
    bq_t f;
    int min_len;
    logic [31:0] fcs;
    exp_t e;
    min_len = (sel == 0) ? 60 : 0;
    f = p;
    while (f.size() < min_len) f.push_back(8'h00);
    fcs = const_fcs ? 32'hCBF43926 : ref_fcs(f);
    foreach (f[i]) begin
      e.d = f[i]; e.last = 1'b0; e.gen = (i >= p.size());
      push_exp(sel, e);
    end
    for (int k = 0; k < 4; k++) begin
      e.d = fcs[8*k +: 8]; e.last = (k == 3); e.gen = 1'b1;
      push_exp(sel, e);
    end
    if (sel == 0) lenq_a.push_back(f.size() + 4);
    else          lenq_b.push_back(f.size() + 4);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic drv(input int sel, input bit v, input logic [7:0] d, input bit l);
    if (sel == 0) begin
      ifa.in_valid_i = v; ifa.in_data_i = d; ifa.in_last_i = l;
    end else begin
      ifb.in_valid_i = v; ifb.in_data_i = d; ifb.in_last_i = l;
    end
  endtask

  function automatic bit rdy(input int sel);
    return (sel == 0) ? ifa.in_ready_o : ifb.in_ready_o;
  endfunction

  task automatic send_frame(input int sel, input bq_t p, input int gap_pct,
                            input bit hold, input bit const_fcs, output int first_cyc);
    bit r;
    int n;
    first_cyc = -1;
    build_expected(sel, p, const_fcs);
    foreach (p[i]) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        drv(sel, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, 3)) cyc();
      end
      drv(sel, 1'b1, p[i], (i == p.size() - 1));
      n = 0;
      do begin
        r = rdy(sel);
        if (r && i == 0) first_cyc = cyc_cnt;
        cyc();
        n++;
      end while (!r && n < 2000);
      if (!r) begin
        total++; bad++;
        $display("FAIL in_accept sel=%0d byte=%0d: in_ready_o never high, required 1 within 2000 cycles", sel, i);
        break;
      end
    end
    if (!hold) drv(sel, 1'b0, 8'h00, 1'b0);
  endtask

  always begin
    @(negedge clk);
    #1;
    ifa.out_ready_i = rand_rdy[0] ? 1'($urandom_range(0, 1)) : 1'b1;
    ifb.out_ready_i = rand_rdy[1] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int sel, input bit rst, input bit v, input bit r,
                     input logic [7:0] d, input bit l, input bit irdy, input logic [15:0] len);
    exp_t e;
    int el;
    bit empty;
    if (rst) begin
      stalled[sel] = 1'b0;
      len_pend[sel] = 1'b0;
      return;
    end
    if (len_pend[sel]) begin
      len_pend[sel] = 1'b0;
      el = -1;
      if (sel == 0 && lenq_a.size() > 0) el = lenq_a.pop_front();
      if (sel == 1 && lenq_b.size() > 0) el = lenq_b.pop_front();
      total++;
      if (int'(len) != el) begin
        bad++;
        $display("FAIL len_o sel=%0d: got %0d, required %0d", sel, len, el);
      end
    end
    if (stalled[sel] && v) begin
      total++;
      if (d != held[sel]) begin
        bad++;
        $display("FAIL stall_hold sel=%0d: out_data_o %02h, required held %02h", sel, d, held[sel]);
      end
    end
    stalled[sel] = v && !r;
    held[sel] = d;
    if (v && r) begin
      empty = (sel == 0) ? (expq_a.size() == 0) : (expq_b.size() == 0);
      total++;
      if (empty) begin
        bad++;
        $display("FAIL unexpected_byte sel=%0d: got %02h last=%0d, required no transfer", sel, d, l);
      end else begin
        e = (sel == 0) ? expq_a.pop_front() : expq_b.pop_front();
        if (d != e.d || l != e.last) begin
          bad++;
          $display("FAIL out_byte sel=%0d: got %02h last=%0d, required %02h last=%0d",
                   sel, d, l, e.d, e.last);
        end
        if (e.gen) begin
          total++;
          if (irdy) begin
            bad++;
            $display("FAIL in_ready_gen sel=%0d: in_ready_o 1 during pad/fcs, required 0", sel);
          end
        end
      end
      if (l) begin
        len_pend[sel] = 1'b1;
        last_fcs_cyc[sel] = cyc_cnt;
      end
    end
  endtask

  always begin
    @(negedge clk);
    #3;
    mon(0, rst_a, ifa.out_valid_o, ifa.out_ready_i, ifa.out_data_o, ifa.out_last_o,
        ifa.in_ready_o, ifa.len_o);
    mon(1, rst_b, ifb.out_valid_o, ifb.out_ready_i, ifb.out_data_o, ifb.out_last_o,
        ifb.in_ready_o, ifb.len_o);
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bq_t p, p2;
    int fc, fc2, n;
    build_tbl();
    rand_rdy[0] = 1'b0;
    rand_rdy[1] = 1'b0;
    drv(0, 1'b0, 8'h00, 1'b0);
    drv(1, 1'b0, 8'h00, 1'b0);
    ifa.out_ready_i = 1'b1;
    ifb.out_ready_i = 1'b1;
    cyc(); cyc();
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("reset_out_valid_a", int'(ifa.out_valid_o), 0);
    chk("reset_busy_a", int'(ifa.busy_o), 0);
    chk("reset_len_a", int'(ifa.len_o), 0);
    chk("reset_out_last_a", int'(ifa.out_last_o), 0);
    chk("reset_out_data_b", int'(ifb.out_data_o), 0);
    chk("reset_busy_b", int'(ifb.busy_o), 0);
    cyc();

    // Check value frame, no padding.
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(1, p, 0, 1'b0, 1'b1, fc);
    $display("frame B check-value 9 bytes queued");

    // Single byte padded to 60.
    p = '{8'hAA};
    send_frame(0, p, 0, 1'b0, 1'b0, fc);
    $display("frame A 1-byte 0xAA queued");

    // Exactly minimum, then one over.
    p = {};
    repeat (60) p.push_back(8'($urandom));
    send_frame(0, p, 0, 1'b0, 1'b0, fc);
    $display("frame A 60 bytes queued");
    p = {};
    repeat (61) p.push_back(8'($urandom));
    send_frame(0, p, 0, 1'b0, 1'b0, fc);
    $display("frame A 61 bytes queued");

    // Random back-pressure and input gaps.
    rand_rdy[0] = 1'b1;
    p = {};
    repeat (100) p.push_back(8'($urandom));
    send_frame(0, p, 30, 1'b0, 1'b0, fc);
    $display("frame A 100 bytes with stalls queued");
    p = {};
    repeat (20) p.push_back(8'($urandom));
    send_frame(0, p, 30, 1'b0, 1'b0, fc);
    $display("frame A 20 bytes with stalls queued");
    rand_rdy[0] = 1'b0;

    // Abort mid-pad with reset.
    n = 0;
    while ((expq_a.size() > 0 || ifa.busy_o) && n < 3000) begin cyc(); n++; end
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(0, p, 0, 1'b0, 1'b0, fc);
    repeat (10) cyc();
    rst_a = 1'b1;
    expq_a.delete();
    lenq_a.delete();
    cyc();
    rst_a = 1'b0;
    #1;
    chk("midpad_reset_out_valid", int'(ifa.out_valid_o), 0);
    chk("midpad_reset_busy", int'(ifa.busy_o), 0);
    chk("midpad_reset_len", int'(ifa.len_o), 0);
    cyc();
    $display("frame A reset mid-pad applied");
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(0, p, 0, 1'b0, 1'b0, fc);
    send_frame(1, p, 0, 1'b0, 1'b1, fc);
    $display("check-value frames after reset queued");

    // Back-to-back frames with in_valid_i held high.
    p = {};
    repeat (10) p.push_back(8'($urandom));
    p2 = {};
    repeat (70) p2.push_back(8'($urandom));
    send_frame(0, p, 0, 1'b1, 1'b0, fc);
    send_frame(0, p2, 0, 1'b0, 1'b0, fc2);
    chk("b2b_first_byte_cycle", fc2, last_fcs_cyc[0] + 1);
    $display("back-to-back frames queued");

    n = 0;
    while ((expq_a.size() > 0 || expq_b.size() > 0) && n < 5000) begin cyc(); n++; end
    repeat (3) cyc();
    total++;
    if (expq_a.size() != 0 || expq_b.size() != 0 || lenq_a.size() != 0 || lenq_b.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d bytes and %0d/%0d lengths left, required 0",
               expq_a.size(), expq_b.size(), lenq_a.size(), lenq_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
